// File: rtl/mbc_pkg.sv
// ---------------------------------------------------------------------------
// mbc_pkg -- shared definitions for the basic-computer control path.
//
// Contents:
//   SC_W     width of the instruction sequence counter
//   T_NUM    number of one-hot timing signals (T0..T15)
//   state_t  sequence-timer FSM states
// ---------------------------------------------------------------------------
package mbc_pkg;

    localparam int SC_W  = 4;
    localparam int T_NUM = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HALTED    = 2'd2,
        STEP_WAIT = 2'd3
    } state_t;

endpackage : mbc_pkg

// File: rtl/sc_decoder.sv
// ---------------------------------------------------------------------------
// sc_decoder -- 4-to-16 one-hot decoder for the sequence counter.
//
// Ports:
//   sc        in   SC_W   sequence counter value
//   t_onehot  out  T_NUM  one-hot timing vector, bit sc set
// ---------------------------------------------------------------------------
module sc_decoder
    import mbc_pkg::*;
(
    input  logic [SC_W-1:0]  sc,
    output logic [T_NUM-1:0] t_onehot
);

    always_comb begin
        // NOTE: a default assignment before any conditional write keeps
        // combinational blocks from inferring latches.
        t_onehot     = '0;
        t_onehot[sc] = 1'b1;
    end

endmodule : sc_decoder

// File: rtl/seq_timer.sv
// ---------------------------------------------------------------------------
// seq_timer -- instruction sequence counter and timing generator.
//
// Generates the one-hot timing signals T0..T15 consumed by the control unit,
// tracks run/halt state, the interrupt-enable flag and the interrupt cycle.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   pulse: begin or resume execution (IDLE/HALTED)
//   sc_clr       in   1   end-of-instruction, restart at T0 (RUN only)
//   halt         in   1   HLT executing, go to HALTED (RUN only)
//   fgi, fgo     in   1   input / output device flags
//   ien_set      in   1   ION strobe
//   ien_clr      in   1   IOF strobe (wins over ien_set)
//   step_mode    in   1   single-step enable
//   step         in   1   single-step advance pulse
//   t_dec        out  16  one-hot timing signals, zero unless running
//   sc           out  4   raw sequence counter
//   running      out  1   FSM in RUN
//   r_cyc        out  1   interrupt cycle active
//   ien          out  1   interrupt enable
//   timeout_err  out  1   sticky: counter wrapped past T15 without sc_clr
//
// Build option:
//   SINGLE_STEP_EN  when defined, step_mode parks the timer in STEP_WAIT at
//                   each instruction end until a step pulse. When undefined,
//                   step_mode/step are ignored and STEP_WAIT is unreachable.
// ---------------------------------------------------------------------------
module seq_timer
    import mbc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sc_clr,
    input  logic             halt,
    input  logic             fgi,
    input  logic             fgo,
    input  logic             ien_set,
    input  logic             ien_clr,
    input  logic             step_mode,
    input  logic             step,
    output logic [T_NUM-1:0] t_dec,
    output logic [SC_W-1:0]  sc,
    output logic             running,
    output logic             r_cyc,
    output logic             ien,
    output logic             timeout_err
);

    state_t           state, state_nxt;
    logic [SC_W-1:0]  sc_q, sc_nxt;
    logic             r_cyc_q, r_cyc_nxt;
    logic             ien_q, ien_nxt;
    logic             timeout_q, timeout_nxt;
    logic [T_NUM-1:0] dec_out;

    logic irq_pend;
    logic run_active;   // in RUN and not being halted this cycle
    logic instr_end;    // accepted end-of-instruction
    logic timeout_hit;  // counter about to wrap from T15

`ifndef SINGLE_STEP_EN
    // Single-step ports stay on the interface but drive nothing.
    logic unused_step_inputs;
    assign unused_step_inputs = step ^ step_mode;
`endif

    assign irq_pend    = ien_q & (fgi | fgo);
    assign run_active  = (state == RUN) && !halt;
    assign instr_end   = run_active && sc_clr;
    assign timeout_hit = run_active && !sc_clr && (sc_q == SC_W'(T_NUM - 1));

    // ---------------------------------------------------------------------
    // State register and datapath flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is a small control flop, so all of them
        // take the async reset; sequential state uses non-blocking (<=)
        // assignments so all flops update together from pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            sc_q      <= '0;
            r_cyc_q   <= 1'b0;
            ien_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            sc_q      <= sc_nxt;
            r_cyc_q   <= r_cyc_nxt;
            ien_q     <= ien_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic. sc only counts while staying in RUN; every other
    // transition (including entry to RUN) loads zero.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        sc_nxt    = '0;
        case (state)
            IDLE, HALTED: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (sc_clr) begin
`ifdef SINGLE_STEP_EN
                    if (step_mode) state_nxt = STEP_WAIT;
`endif
                end else begin
                    sc_nxt = sc_q + SC_W'(1);  // wraps 15 -> 0
                end
            end
            STEP_WAIT: begin
`ifdef SINGLE_STEP_EN
                if (step) state_nxt = RUN;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Interrupt bookkeeping: an instruction end with a pending request opens
    // an interrupt cycle; the end of that cycle closes it and drops ien,
    // overriding any ION issued in the same cycle.
    always_comb begin
        r_cyc_nxt   = r_cyc_q;
        ien_nxt     = ien_q;
        timeout_nxt = timeout_q | timeout_hit;

        if (instr_end) r_cyc_nxt = r_cyc_q ? 1'b0 : irq_pend;

        if (instr_end && r_cyc_q) ien_nxt = 1'b0;
        else if (ien_clr)         ien_nxt = 1'b0;
        else if (ien_set)         ien_nxt = 1'b1;
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    sc_decoder u_sc_decoder (
        .sc       (sc_q),
        .t_onehot (dec_out)
    );

    always_comb begin
        running     = (state == RUN);
        t_dec       = dec_out & {T_NUM{running}};
        sc          = sc_q;
        r_cyc       = r_cyc_q;
        ien         = ien_q;
        timeout_err = timeout_q;
    end

endmodule : seq_timer

// File: tb/tb_seq_timer.sv
// ---------------------------------------------------------------------------
// tb_seq_timer -- directed self-checking bench for seq_timer.
// Inputs change at the falling edge; outputs are sampled at the falling edge
// after each rising edge. Build with SINGLE_STEP_EN defined to cover the
// single-step option.
// ---------------------------------------------------------------------------
module tb_seq_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sc_clr, halt, fgi, fgo;
    logic        ien_set, ien_clr, step_mode, step;
    logic [15:0] t_dec;
    logic [3:0]  sc;
    logic        running, r_cyc, ien, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    seq_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sc_clr      (sc_clr),
        .halt        (halt),
        .fgi         (fgi),
        .fgo         (fgo),
        .ien_set     (ien_set),
        .ien_clr     (ien_clr),
        .step_mode   (step_mode),
        .step        (step),
        .t_dec       (t_dec),
        .sc          (sc),
        .running     (running),
        .r_cyc       (r_cyc),
        .ien         (ien),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " t_dec"},   32'(t_dec), 32'h0);
        check({tag, " sc"},      32'(sc), 32'h0);
        check({tag, " running"}, 32'(running), 32'h0);
        check({tag, " r_cyc"},   32'(r_cyc), 32'h0);
        check({tag, " ien"},     32'(ien), 32'h0);
        check({tag, " terr"},    32'(timeout_err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sc_clr = 1'b0; halt = 1'b0;
        fgi = 1'b0; fgo = 1'b0; ien_set = 1'b0; ien_clr = 1'b0;
        step_mode = 1'b0; step = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle no start t_dec", 32'(t_dec), 32'h0);

        // Start and count T0, T1, T2 ..., sc_clr at T4
        start = 1'b1; tick(); start = 1'b0;
        check("start T0", 32'(t_dec), 32'h0001);
        check("start running", 32'(running), 32'h1);
        tick(); check("T1", 32'(t_dec), 32'h0002);
        tick(); check("T2", 32'(t_dec), 32'h0004);
        tick(); tick();
        check("T4", 32'(t_dec), 32'h0010);
        check("T4 sc", 32'(sc), 32'h4);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        check("sc_clr to T0", 32'(t_dec), 32'h0001);

        // Start is ignored in RUN
        start = 1'b1; tick(); start = 1'b0;
        check("start in RUN ignored", 32'(t_dec), 32'h0002);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;

        // Wrap past T15 sets the sticky timeout error
        repeat (15) tick();
        check("T15 sc", 32'(sc), 32'hf);
        check("T15 t_dec", 32'(t_dec), 32'h8000);
        check("no terr yet", 32'(timeout_err), 32'h0);
        tick();
        check("wrap sc", 32'(sc), 32'h0);
        check("wrap terr", 32'(timeout_err), 32'h1);
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt running", 32'(running), 32'h0);
        check("halt t_dec", 32'(t_dec), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        check("restart T0", 32'(t_dec), 32'h0001);
        check("terr sticky", 32'(timeout_err), 32'h1);

        // Interrupt cycle entry and exit
        ien_set = 1'b1; tick(); ien_set = 1'b0;
        check("ien set", 32'(ien), 32'h1);
        fgi = 1'b1;
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        check("r_cyc set", 32'(r_cyc), 32'h1);
        tick(); tick();
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        check("r_cyc clear", 32'(r_cyc), 32'h0);
        check("ien cleared by r_cyc end", 32'(ien), 32'h0);
        ien_set = 1'b1; ien_clr = 1'b1; tick(); ien_clr = 1'b0;
        check("ien_clr wins", 32'(ien), 32'h0);
        tick();  // ien_set alone
        ien_set = 1'b0;
        check("ien set again", 32'(ien), 32'h1);
        sc_clr = 1'b1; tick();
        check("r_cyc set 2", 32'(r_cyc), 32'h1);
        ien_set = 1'b1; tick(); ien_set = 1'b0; sc_clr = 1'b0;
        check("r_cyc end beats ion", 32'(ien), 32'h0);
        check("r_cyc clear 2", 32'(r_cyc), 32'h0);
        fgi = 1'b0;
        // fgo alone also raises a request
        ien_set = 1'b1; tick(); ien_set = 1'b0;
        fgo = 1'b1; sc_clr = 1'b1; tick(); sc_clr = 1'b0; fgo = 1'b0;
        check("fgo r_cyc", 32'(r_cyc), 32'h1);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        check("fgo r_cyc clear", 32'(r_cyc), 32'h0);

        // halt and sc_clr together at T3
        tick(); tick(); tick();
        check("pre-halt T3", 32'(t_dec), 32'h0008);
        halt = 1'b1; sc_clr = 1'b1; tick(); halt = 1'b0; sc_clr = 1'b0;
        check("halt beats sc_clr running", 32'(running), 32'h0);
        check("halt beats sc_clr t_dec", 32'(t_dec), 32'h0);
        check("halt sc", 32'(sc), 32'h0);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        check("sc_clr in HALTED ignored", 32'(running), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        check("halt restart T0", 32'(t_dec), 32'h0001);

        // Single-step behaviour
        step_mode = 1'b1;
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
`ifdef SINGLE_STEP_EN
        for (int i = 0; i < 5; i++) begin
            check("step wait t_dec", 32'(t_dec), 32'h0);
            tick();
        end
        check("step wait running", 32'(running), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        check("start in STEP_WAIT ignored", 32'(running), 32'h0);
        step = 1'b1; tick(); step = 1'b0;
        check("step to T0", 32'(t_dec), 32'h0001);
`else
        check("no step option T0", 32'(t_dec), 32'h0001);
        step = 1'b1; tick(); step = 1'b0;
        check("step ignored", 32'(t_dec), 32'h0002);
`endif
        // halt still beats entering STEP_WAIT: start must revive it
        halt = 1'b1; sc_clr = 1'b1; tick(); halt = 1'b0; sc_clr = 1'b0;
        check("halt beats step wait", 32'(running), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        check("halt then start T0", 32'(t_dec), 32'h0001);
        step_mode = 1'b0;

        // Asynchronous reset mid-instruction at T2
        ien_set = 1'b1; tick(); ien_set = 1'b0;
        tick();
        check("pre-reset T2", 32'(t_dec), 32'h0004);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        check("no resume running", 32'(running), 32'h0);
        check("no resume t_dec", 32'(t_dec), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_timer

// File: doc/seq_timer.md
SEQ_TIMER -- requirements
Module: seq_timer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle pulse to begin or resume execution.
REQ-004 SHALL have port sc_clr, input, 1, control unit's end-of-instruction request to clear the sequence counter.
REQ-005 SHALL have port halt, input, 1, HLT instruction executing.
REQ-006 SHALL have port fgi and fgo, input, 1 each, input/output device flags.
REQ-007 SHALL have port ien_set and ien_clr, input, 1 each, ION/IOF instruction strobes.
REQ-008 SHALL have port step_mode and step, input, 1 each, single-step enable and advance pulse.
REQ-009 SHALL have port t_dec, output, 16, one-hot timing signals T0..T15 driving the control unit's dec_signal.
REQ-010 SHALL have port sc, output, 4, raw sequence counter value.
REQ-011 SHALL have ports running, r_cyc, ien and timeout_err, output, 1 each, meaning respectively: in RUN state, interrupt cycle active, interrupt enable, sticky SC wrap error.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, HALTED, STEP_WAIT.
REQ-013 In IDLE, HALTED and STEP_WAIT, t_dec SHALL be 0 and sc SHALL hold 0.
REQ-014 IDLE or HALTED with start=1 SHALL go to RUN with sc=0, so T0 is asserted in the next cycle.
REQ-015 In RUN, t_dec SHALL equal one-hot(sc) combinationally; sc SHALL increment by 1 per cycle.
REQ-016 In RUN with sc_clr=1, sc SHALL be 0 on the next cycle (zero-latency restart at T0).
REQ-017 In RUN with sc=15 and sc_clr=0, sc SHALL wrap to 0 and timeout_err SHALL set; timeout_err stays set until reset.
REQ-018 In RUN with halt=1, the next state SHALL be HALTED with sc=0; halt takes priority over sc_clr and over increment.
REQ-019 irq_pend SHALL equal ien & (fgi | fgo).
REQ-020 When sc_clr=1 with r_cyc=0 and irq_pend=1, r_cyc SHALL set for the following instruction slot.
REQ-021 When sc_clr=1 with r_cyc=1, r_cyc SHALL clear and ien SHALL clear.
REQ-022 ien SHALL set on ien_set; ien_clr SHALL win when both strobes are asserted together.
REQ-023 The REQ-021 clear SHALL override ien_set in the same cycle.
REQ-024 start SHALL be ignored in RUN and in STEP_WAIT.
REQ-025 sc_clr and halt SHALL be ignored outside RUN.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force: state IDLE, sc=0, t_dec=0, running=0, r_cyc=0, ien=0, timeout_err=0.
REQ-027 Reset mid-instruction SHALL abandon the instruction; there is no resume without start.

Configuration
REQ-028 With SINGLE_STEP_EN defined: in RUN with step_mode=1 and sc_clr=1, the next state SHALL be STEP_WAIT.
REQ-029 With SINGLE_STEP_EN defined: STEP_WAIT with step=1 SHALL go to RUN with sc=0.
REQ-030 With SINGLE_STEP_EN defined: halt SHALL still take priority over entering STEP_WAIT.
REQ-031 Without SINGLE_STEP_EN: step_mode and step SHALL be ignored, STEP_WAIT SHALL be unreachable, and the ports SHALL remain present.

Structure
REQ-032 A shared package mbc_pkg SHALL hold the FSM state enum, SC_W=4, and T_NUM=16.
REQ-033 The block SHALL instantiate one sub-module, sc_decoder (4-to-16 one-hot decoder), to produce t_dec; the decoder output SHALL be gated by running.

Verification
REQ-034 Reset then start pulse: t_dec SHALL be 0x0001, 0x0002, 0x0004 on consecutive cycles; sc_clr at T4 SHALL produce 0x0001 on the next cycle.
REQ-035 Run 16 cycles without sc_clr: sc SHALL go 15 -> 0, and timeout_err SHALL be 1 and stay 1 after a later start.
REQ-036 ien_set, then fgi=1, then sc_clr: r_cyc SHALL be 1; the next sc_clr SHALL give r_cyc=0 and ien=0.
REQ-037 halt and sc_clr asserted together at T3: state SHALL be HALTED, t_dec=0, running=0; start SHALL restart at T0.
REQ-038 SINGLE_STEP_EN with step_mode=1: sc_clr SHALL give t_dec=0 held for 5 cycles; a step pulse SHALL give T0 on the next cycle. Without the macro, the same stimulus SHALL give T0 immediately after sc_clr.
REQ-039 rst_n asserted low at T2, asynchronously between clock edges: all outputs SHALL be 0 immediately.
